// File: rtl/bram_image_writer_pkg.sv
// rtl/bram_image_writer_pkg.sv - frame geometry and writer FSM encoding shared with the VGA display path
package bram_image_writer_pkg;

    localparam int IMG_W_DEF     = 640;
    localparam int IMG_H_DEF     = 480;
    localparam int PIX_TOTAL_DEF = IMG_W_DEF * IMG_H_DEF;
    localparam int ADDR_W_DEF    = 19;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } writer_state_t;

endpackage

// File: rtl/bram_image_writer.sv
// rtl/bram_image_writer.sv - unpacks a byte stream into a 1-bit-per-pixel frame on BRAM port A
module bram_image_writer
    import bram_image_writer_pkg::*;
#(
    parameter int IMG_W  = IMG_W_DEF,
    parameter int IMG_H  = IMG_H_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              VGA_480_CLK,
    input  logic              rst,
    input  logic              start,
    input  logic              invert,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              wea,
    output logic [ADDR_W-1:0] addra,
    output logic              dina,
    output logic              busy,
    output logic              frame_done
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_W * IMG_H - 1);

    writer_state_t     state;
    writer_state_t     next_state;
    logic [ADDR_W-1:0] pix_addr;
    logic [6:0]        shift_reg;
    logic [2:0]        bit_cnt;
    logic              inv_q;

    // bit_cnt is the index of the bit currently presented on dina; the
    // frame ends after the eighth bit of the byte that hit the last pixel.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:  if (start) next_state = ST_LOAD;
            ST_LOAD:  if (byte_valid) next_state = ST_SHIFT;
            ST_SHIFT: if (bit_cnt == 3'd7) next_state = (addra == LAST_ADDR) ? ST_DONE : ST_LOAD;
            ST_DONE:  next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge VGA_480_CLK) begin
        if (rst) begin
            state      <= ST_IDLE;
            pix_addr   <= '0;
            shift_reg  <= '0;
            bit_cnt    <= '0;
            inv_q      <= 1'b0;
            byte_ready <= 1'b0;
            wea        <= 1'b0;
            addra      <= '0;
            dina       <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= next_state;
            byte_ready <= (next_state == ST_LOAD);
            busy       <= (next_state != ST_IDLE);
            frame_done <= (next_state == ST_DONE);
            wea        <= (next_state == ST_SHIFT);
            // The MSB goes out on the acceptance edge so that eight writes
            // fill the eight SHIFT cycles; addra only moves on a write.
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        inv_q    <= invert;
                        pix_addr <= '0;
                    end
                end
                ST_LOAD: begin
                    if (byte_valid) begin
                        shift_reg <= byte_in[6:0];
                        bit_cnt   <= 3'd0;
                        addra     <= pix_addr;
                        dina      <= byte_in[7] ^ inv_q;
                        pix_addr  <= pix_addr + ADDR_W'(1);
                    end
                end
                ST_SHIFT: begin
                    if (bit_cnt != 3'd7) begin
                        shift_reg <= {shift_reg[5:0], 1'b0};
                        bit_cnt   <= bit_cnt + 3'd1;
                        addra     <= pix_addr;
                        dina      <= shift_reg[6] ^ inv_q;
                        pix_addr  <= pix_addr + ADDR_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
